// File: rtl/multi_clock_divider_if.sv
// Control and output bundle for multi_clock_divider: run enables, divide-value
// write port, and the divided clocks with their tick/load_pending status.
interface multi_clock_divider_if #(
   parameter int N      = 32,
   parameter int NUM_CH = 4
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] en;
   logic              wr_en;
   logic [CHW-1:0]    wr_ch;
   logic [N-1:0]      wr_data;
   logic [NUM_CH-1:0] outclk;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] load_pending;

   modport master (
      output en, wr_en, wr_ch, wr_data,
      input  outclk, tick, load_pending
   );

   modport slave (
      input  en, wr_en, wr_ch, wr_data,
      output outclk, tick, load_pending
   );
endinterface

// File: rtl/multi_clock_divider.sv
// NUM_CH independent square-wave dividers with double-buffered divide values.
// Define CLKDIV_SYNC_START_EN to add the sync_start phase-alignment input.
module multi_clock_divider #(
   parameter int N           = 32,
   parameter int NUM_CH      = 4,
   parameter int DEFAULT_DIV = 0
) (
   input  logic inclk,
   input  logic reset,
`ifdef CLKDIV_SYNC_START_EN
   input  logic sync_start,
`endif
   multi_clock_divider_if.slave bus
);
   localparam int           CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [N-1:0] DEF = N'(DEFAULT_DIV);

   logic [N-1:0]      cnt         [NUM_CH];
   logic [N-1:0]      active_div  [NUM_CH];
   logic [N-1:0]      pending_div [NUM_CH];
   logic [NUM_CH-1:0] outclk_r;
   logic [NUM_CH-1:0] tick_r;
   logic [NUM_CH-1:0] pend_r;
   logic [NUM_CH-1:0] wr_hit;

   // An out-of-range wr_ch matches no channel index, so such writes fall away.
   always_comb begin
      wr_hit = '0;
      for (int unsigned i = 0; i < NUM_CH; i++)
         wr_hit[i] = bus.wr_en && (bus.wr_ch == CHW'(i));
   end

   always_ff @(posedge inclk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt[i]         <= '0;
            active_div[i]  <= DEF;
            pending_div[i] <= DEF;
         end
         outclk_r <= '0;
         tick_r   <= '0;
         pend_r   <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef CLKDIV_SYNC_START_EN
            if (sync_start) begin
               cnt[i]      <= '0;
               outclk_r[i] <= 1'b0;
               tick_r[i]   <= 1'b0;
               pend_r[i]   <= 1'b0;
               if (wr_hit[i]) begin
                  active_div[i]  <= bus.wr_data;
                  pending_div[i] <= bus.wr_data;
               end else if (pend_r[i]) begin
                  active_div[i] <= pending_div[i];
               end
            end else
`endif
            if (!bus.en[i]) begin
               cnt[i]      <= '0;
               outclk_r[i] <= 1'b0;
               tick_r[i]   <= 1'b0;
               if (wr_hit[i]) begin
                  active_div[i]  <= bus.wr_data;
                  pending_div[i] <= bus.wr_data;
                  pend_r[i]      <= 1'b0;
               end
            end else if (cnt[i] == active_div[i]) begin
               // active_div only ever changes here, where cnt restarts at 0
               cnt[i]      <= '0;
               outclk_r[i] <= ~outclk_r[i];
               tick_r[i]   <= 1'b1;
               if (wr_hit[i]) begin
                  active_div[i] <= bus.wr_data;
                  pend_r[i]     <= 1'b0;
               end else if (pend_r[i]) begin
                  active_div[i] <= pending_div[i];
                  pend_r[i]     <= 1'b0;
               end
            end else begin
               cnt[i]    <= cnt[i] + 1'b1;
               tick_r[i] <= 1'b0;
               if (wr_hit[i]) begin
                  pending_div[i] <= bus.wr_data;
                  pend_r[i]      <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.outclk       = outclk_r;
   assign bus.tick         = tick_r;
   assign bus.load_pending = pend_r;
endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (N=8, NUM_CH=3, DEFAULT_DIV=0);
// covers the sync_start path when CLKDIV_SYNC_START_EN is defined.
module tb_multi_clock_divider;
   localparam int N      = 8;
   localparam int NUM_CH = 3;

   logic inclk;
   logic reset;
`ifdef CLKDIV_SYNC_START_EN
   logic sync_start;
`endif
   int n_checks;
   int n_fail;

   multi_clock_divider_if #(.N(N), .NUM_CH(NUM_CH)) bus ();

   multi_clock_divider #(
      .N(N),
      .NUM_CH(NUM_CH),
      .DEFAULT_DIV(0)
   ) dut (
      .inclk(inclk),
      .reset(reset),
`ifdef CLKDIV_SYNC_START_EN
      .sync_start(sync_start),
`endif
      .bus(bus.master)
   );

   initial inclk = 1'b0;
   always #5 inclk = ~inclk;

   task automatic step();
      @(posedge inclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic [N-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_ch   = ch;
      bus.wr_data = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b0;
      bus.en      = '0;
      bus.wr_en   = 1'b0;
      bus.wr_ch   = '0;
      bus.wr_data = '0;
`ifdef CLKDIV_SYNC_START_EN
      sync_start  = 1'b0;
`endif
      #2 reset = 1'b1;
      #1;
      chk("reset_outclk", 32'(bus.outclk), 32'h0);
      chk("reset_tick", 32'(bus.tick), 32'h0);
      chk("reset_pending", 32'(bus.load_pending), 32'h0);
      step();
      reset  = 1'b0;

      // ch0 with default D=0 toggles every edge
      bus.en = 3'b001;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk("d0_outclk0", 32'(bus.outclk[0]), 32'(e % 2));
         chk("d0_tick0", 32'(bus.tick[0]), 32'h1);
      end

      // ch1 D=4 written while disabled, then enabled
      wr(2'd1, 8'd4);
      step();
      bus.wr_en = 1'b0;
      chk("dis_write_pending1", 32'(bus.load_pending[1]), 32'h0);
      bus.en = 3'b011;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk("d4_outclk1", 32'(bus.outclk[1]), (e >= 5 && e < 10) ? 32'h1 : 32'h0);
         chk("d4_tick1", 32'(bus.tick[1]), (e == 5 || e == 10) ? 32'h1 : 32'h0);
      end

      // mid-period write D=1 at cnt=2 is held until the next wrap
      step();
      step();
      wr(2'd1, 8'd1);
      step();
      bus.wr_en = 1'b0;
      chk("pend_set1", 32'(bus.load_pending[1]), 32'h1);
      chk("pend_outclk1_a", 32'(bus.outclk[1]), 32'h0);
      step();
      chk("pend_hold1", 32'(bus.load_pending[1]), 32'h1);
      chk("pend_outclk1_b", 32'(bus.outclk[1]), 32'h0);
      step();
      chk("pend_wrap_outclk1", 32'(bus.outclk[1]), 32'h1);
      chk("pend_wrap_tick1", 32'(bus.tick[1]), 32'h1);
      chk("pend_clear1", 32'(bus.load_pending[1]), 32'h0);
      step();
      chk("d1_outclk1_a", 32'(bus.outclk[1]), 32'h1);
      chk("d1_tick1_a", 32'(bus.tick[1]), 32'h0);
      step();
      chk("d1_outclk1_b", 32'(bus.outclk[1]), 32'h0);
      chk("d1_tick1_b", 32'(bus.tick[1]), 32'h1);
      step();
      chk("d1_outclk1_c", 32'(bus.outclk[1]), 32'h0);
      step();
      chk("d1_outclk1_d", 32'(bus.outclk[1]), 32'h1);

      // ch2: D=2, then write D=7 on the exact wrap edge (write-through)
      wr(2'd2, 8'd2);
      step();
      bus.wr_en = 1'b0;
      bus.en    = 3'b111;
      step();
      step();
      chk("wt_pre_outclk2", 32'(bus.outclk[2]), 32'h0);
      wr(2'd2, 8'd7);
      step();
      bus.wr_en = 1'b0;
      chk("wt_outclk2", 32'(bus.outclk[2]), 32'h1);
      chk("wt_tick2", 32'(bus.tick[2]), 32'h1);
      chk("wt_pending2", 32'(bus.load_pending[2]), 32'h0);
      for (int k = 4; k <= 11; k++) begin
         step();
         chk("wt_pending2_run", 32'(bus.load_pending[2]), 32'h0);
         chk("wt_outclk2_run", 32'(bus.outclk[2]), (k < 11) ? 32'h1 : 32'h0);
         chk("wt_tick2_run", 32'(bus.tick[2]), (k == 11) ? 32'h1 : 32'h0);
      end

      // ch0: stop, set D=2, enable, drop mid-period, re-enable
      bus.en = 3'b110;
      step();
      chk("stop_outclk0", 32'(bus.outclk[0]), 32'h0);
      chk("stop_tick0", 32'(bus.tick[0]), 32'h0);
      wr(2'd0, 8'd2);
      step();
      bus.wr_en = 1'b0;
      chk("dis_write_pending0", 32'(bus.load_pending[0]), 32'h0);
      bus.en = 3'b111;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("d2_outclk0", 32'(bus.outclk[0]), (k == 3) ? 32'h1 : 32'h0);
         chk("d2_tick0", 32'(bus.tick[0]), (k == 3) ? 32'h1 : 32'h0);
      end
      step();
      chk("mid_outclk0", 32'(bus.outclk[0]), 32'h1);
      bus.en = 3'b110;
      step();
      chk("drop_outclk0", 32'(bus.outclk[0]), 32'h0);
      bus.en = 3'b111;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("restart_outclk0", 32'(bus.outclk[0]), (k == 3) ? 32'h1 : 32'h0);
         chk("restart_tick0", 32'(bus.tick[0]), (k == 3) ? 32'h1 : 32'h0);
      end

      // out-of-range channel write is ignored
      wr(2'd3, 8'd3);
      step();
      bus.wr_en = 1'b0;
      chk("bad_ch_pending", 32'(bus.load_pending), 32'h0);
      step();
      chk("bad_ch_outclk0", 32'(bus.outclk[0]), 32'h1);
      step();
      chk("bad_ch_wrap_outclk0", 32'(bus.outclk[0]), 32'h0);
      chk("bad_ch_wrap_tick0", 32'(bus.tick[0]), 32'h1);

      // maximum divide value D=2^N-1 on ch1
      bus.en = 3'b101;
      step();
      wr(2'd1, 8'hFF);
      step();
      bus.wr_en = 1'b0;
      bus.en    = 3'b111;
      for (int k = 1; k <= 256; k++) begin
         step();
         if (k == 255) begin
            chk("max_pre_outclk1", 32'(bus.outclk[1]), 32'h0);
            chk("max_pre_tick1", 32'(bus.tick[1]), 32'h0);
         end
         if (k == 256) begin
            chk("max_outclk1", 32'(bus.outclk[1]), 32'h1);
            chk("max_tick1", 32'(bus.tick[1]), 32'h1);
         end
      end

      // asynchronous reset between edges restores defaults
      #3 reset = 1'b1;
      #1;
      chk("async_outclk", 32'(bus.outclk), 32'h0);
      chk("async_tick", 32'(bus.tick), 32'h0);
      chk("async_pending", 32'(bus.load_pending), 32'h0);
      step();
      reset  = 1'b0;
      bus.en = 3'b010;
      step();
      chk("post_rst_outclk1", 32'(bus.outclk[1]), 32'h1);
      chk("post_rst_tick1", 32'(bus.tick[1]), 32'h1);
      step();
      chk("post_rst_outclk1_b", 32'(bus.outclk[1]), 32'h0);

`ifdef CLKDIV_SYNC_START_EN
      bus.en = 3'b000;
      step();
      wr(2'd0, 8'd2);
      step();
      wr(2'd1, 8'd5);
      step();
      bus.wr_en = 1'b0;
      bus.en    = 3'b011;
      for (int k = 1; k <= 4; k++) step();
      chk("sync_pre_outclk0", 32'(bus.outclk[0]), 32'h1);
      sync_start = 1'b1;
      step();
      sync_start = 1'b0;
      chk("sync_outclk", 32'(bus.outclk[1:0]), 32'h0);
      chk("sync_tick", 32'(bus.tick[1:0]), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 3) chk("sync_k3_outclk", 32'(bus.outclk[1:0]), 32'h1);
         if (k == 6) chk("sync_k6_outclk", 32'(bus.outclk[1:0]), 32'h2);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
